// File: rtl/sme_host_driver.sv
// Host-side transmitter for the string matching engine: buffers one string and one
// pattern, streams them to the SME on start, then captures the engine's result.
//
// Ports:
//   clk, reset                  clock and synchronous active-low reset
//   cfg_we/sel/addr/data        buffer write port, honoured only while idle
//   str_len, pat_len            job lengths, latched when a job is accepted
//   new_string, start           job control; start is sampled only while idle
//   chardata/isstring/ispattern character stream towards the SME
//   sme_valid/match/index       result handshake from the SME
//   busy, done                  job in progress / one-cycle completion pulse
//   res_match, res_index        captured result, held until the next accepted start
//   timeout_err, len_err        abort flags, held until the next accepted start
module sme_host_driver #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic       cfg_sel,
    input  logic [5:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    input  logic       new_string,
    input  logic       start,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_index,
    output logic       busy,
    output logic       done,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       timeout_err,
    output logic       len_err
);

    localparam int SIW = $clog2(STR_MAX);
    localparam int PIW = $clog2(PAT_MAX);
    localparam int WCW = $clog2(TIMEOUT + 1);

    localparam logic [5:0]     STR_MAX_L = 6'(STR_MAX);
    localparam logic [5:0]     PAT_MAX_A = 6'(PAT_MAX);
    localparam logic [3:0]     PAT_MAX_L = 4'(PAT_MAX);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_STR,
        S_SEND_PAT,
        S_WAIT,
        S_DONE
    } state_e;

    state_e         state_q;
    logic [5:0]     cnt_q;
    logic [WCW-1:0] wcnt_q;
    logic [5:0]     slen_q;
    logic [3:0]     plen_q;
    logic           str_sent_q;

    logic [7:0]     chardata_q;
    logic           isstring_q;
    logic           ispattern_q;
    logic           busy_q;
    logic           done_q;
    logic           res_match_q;
    logic [4:0]     res_index_q;
    logic           timeout_err_q;
    logic           len_err_q;

    logic [7:0]     str_buf [STR_MAX];
    logic [7:0]     pat_buf [PAT_MAX];

    logic           str_wr;
    logic           pat_wr;
    logic           send_str_d;
    logic           len_bad_d;
    logic [7:0]     str0_d;
    logic [7:0]     pat0_d;

    assign str_wr = (state_q == S_IDLE) && cfg_we && !cfg_sel
                    && (cfg_addr < STR_MAX_L);
    assign pat_wr = (state_q == S_IDLE) && cfg_we && cfg_sel
                    && (cfg_addr < PAT_MAX_A);

    assign send_str_d = new_string | ~str_sent_q;

    assign len_bad_d = (pat_len == 4'd0) || (pat_len > PAT_MAX_L)
                       || (send_str_d && ((str_len == 6'd0)
                                          || (str_len > STR_MAX_L)));

    // A write landing in the same cycle as start must be seen by the job;
    // only character 0 is read on that edge, so forward just that slot.
    assign str0_d = (str_wr && cfg_addr == 6'd0) ? cfg_data : str_buf[0];
    assign pat0_d = (pat_wr && cfg_addr == 6'd0) ? cfg_data : pat_buf[0];

    // Buffers have no reset so their contents survive a reset.
    always_ff @(posedge clk) begin
        if (reset && str_wr) begin
            str_buf[cfg_addr[SIW-1:0]] <= cfg_data;
        end
        if (reset && pat_wr) begin
            pat_buf[cfg_addr[PIW-1:0]] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wcnt_q        <= '0;
            slen_q        <= '0;
            plen_q        <= '0;
            str_sent_q    <= 1'b0;
            chardata_q    <= '0;
            isstring_q    <= 1'b0;
            ispattern_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            res_match_q   <= 1'b0;
            res_index_q   <= '0;
            timeout_err_q <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q        <= 1'b1;
                        res_match_q   <= 1'b0;
                        res_index_q   <= '0;
                        timeout_err_q <= 1'b0;
                        len_err_q     <= 1'b0;
                        slen_q        <= str_len;
                        plen_q        <= pat_len;
                        cnt_q         <= 6'd1;
                        if (len_bad_d) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            len_err_q <= 1'b1;
                        end else if (send_str_d) begin
                            state_q    <= S_SEND_STR;
                            isstring_q <= 1'b1;
                            chardata_q <= str0_d;
                        end else begin
                            state_q     <= S_SEND_PAT;
                            ispattern_q <= 1'b1;
                            chardata_q  <= pat0_d;
                        end
                    end
                end

                S_SEND_STR: begin
                    if (cnt_q < slen_q) begin
                        chardata_q <= str_buf[cnt_q[SIW-1:0]];
                        cnt_q      <= cnt_q + 6'd1;
                    end else begin
                        // Pattern follows the last string char with no gap.
                        state_q     <= S_SEND_PAT;
                        str_sent_q  <= 1'b1;
                        isstring_q  <= 1'b0;
                        ispattern_q <= 1'b1;
                        chardata_q  <= pat_buf[0];
                        cnt_q       <= 6'd1;
                    end
                end

                S_SEND_PAT: begin
                    if (cnt_q < {2'b00, plen_q}) begin
                        chardata_q <= pat_buf[cnt_q[PIW-1:0]];
                        cnt_q      <= cnt_q + 6'd1;
                    end else begin
                        state_q     <= S_WAIT;
                        ispattern_q <= 1'b0;
                        chardata_q  <= '0;
                        wcnt_q      <= '0;
                    end
                end

                S_WAIT: begin
                    // A result arriving on the final wait cycle still counts.
                    if (sme_valid) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        res_match_q <= sme_match;
                        res_index_q <= sme_index;
                    end else if (wcnt_q == WAIT_LAST) begin
                        state_q       <= S_DONE;
                        done_q        <= 1'b1;
                        timeout_err_q <= 1'b1;
                        res_match_q   <= 1'b0;
                        res_index_q   <= '0;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign chardata    = chardata_q;
    assign isstring    = isstring_q;
    assign ispattern   = ispattern_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign res_match   = res_match_q;
    assign res_index   = res_index_q;
    assign timeout_err = timeout_err_q;
    assign len_err     = len_err_q;

endmodule
